// File: rtl/countdown_timer.sv
// Minute:second countdown timer with digit-by-digit preset, start/pause,
// expiry pulse and a tick-timed buzzer that any key press can silence.
module countdown_timer #(
  parameter int unsigned TIMER_MODE   = 2,
  parameter int unsigned BUZZ_SECONDS = 10
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       tick,
  input  logic [3:0] KEY,
  input  logic [2:0] editCur,
  input  logic [1:0] disMode,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       buzz
);

  localparam int unsigned TW    = 6;
  localparam int unsigned CNT_W = (BUZZ_SECONDS < 2) ? 1 : $clog2(BUZZ_SECONDS + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       key_q, key_prev_q;
  logic [3:0]       press_c;
  logic             mode_c, any_press_c, zero_c, last_sec_c, cnt_last_c;
  logic             act_clr_c, act_start_c, act_inc_c, act_dec_c;
  logic [TW-1:0]    min_q, min_d, sec_q, sec_d;
  logic [TW-1:0]    min_edit_c, sec_edit_c;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d, done_q, done_d, buzz_q, buzz_d;

  // Wrap one decimal digit of a 0..59 value without touching its neighbour.
  function automatic logic [TW-1:0] edit_digit(input logic [TW-1:0] val,
                                               input logic tens, input logic up);
    logic [TW-1:0] t, u;
    t = val / 6'd10;
    u = val % 6'd10;
    if (tens) t = up ? ((t >= 6'd5) ? 6'd0 : t + 6'd1) : ((t == 6'd0) ? 6'd5 : t - 6'd1);
    else      u = up ? ((u >= 6'd9) ? 6'd0 : u + 6'd1) : ((u == 6'd0) ? 6'd9 : u - 6'd1);
    return TW'(t * 6'd10) + u;
  endfunction

  // Press detection from the key history and priority resolution.
  assign press_c     = key_prev_q & ~key_q;
  assign any_press_c = |press_c;
  assign mode_c      = (disMode == 2'(TIMER_MODE));
  assign act_clr_c   = mode_c & press_c[3];
  assign act_start_c = mode_c & ~press_c[3] & press_c[0];
  assign act_inc_c   = mode_c & ~press_c[3] & ~press_c[0] & press_c[1];
  assign act_dec_c   = mode_c & ~press_c[3] & ~press_c[0] & ~press_c[1] & press_c[2];

  assign zero_c     = (min_q == '0) && (sec_q == '0);
  assign last_sec_c = (min_q == '0) && (sec_q == 6'd1);
  assign cnt_last_c = (cnt_q <= CNT_W'(1));
  assign min_edit_c = edit_digit(min_q, editCur == 3'd2, act_inc_c);
  assign sec_edit_c = edit_digit(sec_q, editCur == 3'd4, act_inc_c);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; an acting key always pre-empts the tick.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (act_start_c && !zero_c) state_d = S_RUN;
      end
      S_RUN: begin
        if (act_clr_c)                state_d = S_IDLE;
        else if (act_start_c)         state_d = S_PAUSE;
        else if (tick && last_sec_c)  state_d = S_EXPIRED;
      end
      S_PAUSE: begin
        if (act_clr_c)                    state_d = S_IDLE;
        else if (act_start_c && !zero_c)  state_d = S_RUN;
      end
      S_EXPIRED: begin
        if (any_press_c)               state_d = S_IDLE;
        else if (tick && cnt_last_c)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values.
  always_comb begin
    min_d  = min_q;
    sec_d  = sec_q;
    cnt_d  = cnt_q;
    buzz_d = buzz_q;
    done_d = 1'b0;
    run_d  = (state_d == S_RUN);
    unique case (state_q)
      S_IDLE, S_PAUSE: begin
        if (act_clr_c) begin
          min_d = '0;
          sec_d = '0;
        end else if (act_inc_c || act_dec_c) begin
          if (editCur == 3'd2 || editCur == 3'd3) min_d = min_edit_c;
          if (editCur == 3'd4 || editCur == 3'd5) sec_d = sec_edit_c;
        end
      end
      S_RUN: begin
        if (act_clr_c) begin
          min_d = '0;
          sec_d = '0;
        end else if (!act_start_c && tick) begin
          if (sec_q != '0) begin
            sec_d = sec_q - 6'd1;
          end else begin
            sec_d = 6'd59;
            min_d = min_q - 6'd1;
          end
          if (last_sec_c) begin
            done_d = 1'b1;
            buzz_d = 1'b1;
            cnt_d  = CNT_W'(BUZZ_SECONDS);
          end
        end
      end
      S_EXPIRED: begin
        min_d = '0;
        sec_d = '0;
        if (any_press_c) begin
          buzz_d = 1'b0;
          cnt_d  = '0;
        end else if (tick) begin
          if (cnt_last_c) begin
            buzz_d = 1'b0;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      key_q      <= 4'hF;
      key_prev_q <= 4'hF;
      min_q      <= '0;
      sec_q      <= '0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      buzz_q     <= 1'b0;
    end else begin
      key_q      <= KEY;
      key_prev_q <= key_q;
      min_q      <= min_d;
      sec_q      <= sec_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
      done_q     <= done_d;
      buzz_q     <= buzz_d;
    end
  end

  assign minutes = min_q;
  assign seconds = sec_q;
  assign running = run_q;
  assign done    = done_q;
  assign buzz    = buzz_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random key/tick traffic
// against a reference model that keeps the remaining time as total seconds.
module tb_countdown_timer;

  localparam int BUZZ = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

  logic       Clk, nReset, tick;
  logic [3:0] KEY;
  logic [2:0] editCur;
  logic [1:0] disMode;
  logic [5:0] minutes, seconds;
  logic       running, done, buzz;

  countdown_timer #(.TIMER_MODE(2), .BUZZ_SECONDS(BUZZ)) dut (
    .Clk(Clk), .nReset(nReset), .tick(tick), .KEY(KEY), .editCur(editCur),
    .disMode(disMode), .minutes(minutes), .seconds(seconds),
    .running(running), .done(done), .buzz(buzz)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int         m_total, m_state, m_cnt;
  bit         m_buzz, m_done;
  logic [3:0] m_hist, m_prev;

  task automatic model_reset();
    m_total = 0; m_state = M_IDLE; m_cnt = 0; m_buzz = 0; m_done = 0;
    m_hist = 4'hF; m_prev = 4'hF;
  endtask

  function automatic int edit_total(int total, int cur, bit up);
    int d[4];
    int i, lim;
    d[0] = total / 600; d[1] = (total / 60) % 10;
    d[2] = (total % 60) / 10; d[3] = total % 10;
    if (cur < 2 || cur > 5) return total;
    i = cur - 2;
    lim = (i % 2 == 0) ? 5 : 9;
    d[i] = up ? ((d[i] == lim) ? 0 : d[i] + 1) : ((d[i] == 0) ? lim : d[i] - 1);
    return (d[0] * 10 + d[1]) * 60 + d[2] * 10 + d[3];
  endfunction

  task automatic model_step();
    logic [3:0] press;
    int  k;
    bit  acted;
    press  = m_prev & ~m_hist;
    m_prev = m_hist;
    m_hist = KEY;
    m_done = 0;
    if (m_state == M_EXP) begin
      if (press != 0) begin
        m_state = M_IDLE; m_buzz = 0; m_cnt = 0;
      end else if (tick) begin
        m_cnt = m_cnt - 1;
        if (m_cnt <= 0) begin m_cnt = 0; m_buzz = 0; m_state = M_IDLE; end
      end
    end else begin
      acted = 0; k = -1;
      if (disMode == 2'd2) begin
        if (press[3]) k = 3; else if (press[0]) k = 0;
        else if (press[1]) k = 1; else if (press[2]) k = 2;
      end
      case (k)
        3: begin m_total = 0; m_state = M_IDLE; acted = 1; end
        0: if (m_state == M_RUN) begin m_state = M_PAUSE; acted = 1; end
           else if (m_total != 0) begin m_state = M_RUN; acted = 1; end
        1, 2: if (m_state != M_RUN) begin
                acted = 1;
                m_total = edit_total(m_total, int'(editCur), k == 1);
              end
        default: ;
      endcase
      if (!acted && m_state == M_RUN && tick) begin
        m_total = m_total - 1;
        if (m_total == 0) begin
          m_state = M_EXP; m_done = 1; m_buzz = 1; m_cnt = BUZZ;
        end
      end
    end
  endtask

  function automatic logic [14:0] exp_vec();
    return {6'(m_total / 60), 6'(m_total % 60), m_state == M_RUN, m_done, m_buzz};
  endfunction

  task automatic step();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic press(input int k, input bit with_tick);
    KEY[k] = 1'b0;
    step();
    KEY = 4'hF;
    tick = with_tick;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic tick_once();
    tick = 1'b1; step(); tick = 1'b0; step();
  endtask

  task automatic test_reset();
    nReset = 1'b0; tick = 1'b0; KEY = 4'hF; editCur = 3'd0; disMode = 2'd2;
    model_reset();
    #12;
    checks++; if ({minutes, seconds} !== 12'd0) begin errors++; $display("FAIL reset_time: got %0d:%0d expected 0:0", minutes, seconds); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL reset_buzz: got %b expected 0", buzz); end
    #1 nReset = 1'b1;
  endtask

  task automatic test_preset();
    editCur = 3'd3;
    repeat (3) press(1, 0);
    editCur = 3'd4;
    press(1, 0);
    checks++; if ({minutes, seconds} !== {6'd3, 6'd10}) begin errors++; $display("FAIL preset_0310: got %0d:%0d expected 3:10", minutes, seconds); end
    editCur = 3'd2;
    press(2, 0);
    checks++; if (minutes !== 6'd53) begin errors++; $display("FAIL preset_tens_wrap: got %0d expected 53", minutes); end
    checks++; if ({minutes, seconds, running, done, buzz} !== exp_vec()) begin errors++; $display("FAIL preset_model: got %h expected %h", {minutes, seconds, running, done, buzz}, exp_vec()); end
  endtask

  task automatic test_expire();
    int ndone;
    press(3, 0);
    editCur = 3'd3; press(1, 0);
    editCur = 3'd5; press(1, 0);
    checks++; if ({minutes, seconds} !== {6'd1, 6'd1}) begin errors++; $display("FAIL exp_preset: got %0d:%0d expected 1:1", minutes, seconds); end
    press(0, 0);
    tick_once(); tick_once();
    checks++; if ({minutes, seconds, running} !== {6'd0, 6'd59, 1'b1}) begin errors++; $display("FAIL exp_borrow: got %0d:%0d run=%b expected 0:59 run=1", minutes, seconds, running); end
    ndone = 0;
    for (int i = 0; i < 59; i++) begin
      tick = 1'b1; step(); if (done) ndone++;
      checks++; if ({minutes, seconds, running, done, buzz} !== exp_vec()) begin errors++; $display("FAIL exp_count: got %h expected %h", {minutes, seconds, running, done, buzz}, exp_vec()); end
      tick = 1'b0; step(); if (done) ndone++;
    end
    checks++; if (ndone !== 1) begin errors++; $display("FAIL exp_done_width: got %0d cycles expected 1", ndone); end
    checks++; if ({minutes, seconds, running, buzz} !== {12'd0, 1'b0, 1'b1}) begin errors++; $display("FAIL exp_state: got %0d:%0d run=%b buzz=%b expected 0:0 run=0 buzz=1", minutes, seconds, running, buzz); end
    for (int i = 0; i < 10; i++) begin
      tick_once();
      if (i == 8) begin
        checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL buzz_hold: got %b expected 1 after 9 ticks", buzz); end
      end
    end
    checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL buzz_timeout: got %b expected 0 after 10 ticks", buzz); end
    press(1, 0);
    checks++; if (seconds !== 6'd1) begin errors++; $display("FAIL idle_after_buzz: got %0d expected 1", seconds); end
    press(0, 0);
    tick_once();
    checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL reexpire: got %b expected 1", buzz); end
    disMode = 2'd0;
    KEY[2] = 1'b0; step(); KEY = 4'hF; step();
    checks++; if (buzz !== 1'b0) begin errors++; $display("FAIL silence: got %b expected 0", buzz); end
    checks++; if ({minutes, seconds, running, done, buzz} !== exp_vec()) begin errors++; $display("FAIL silence_model: got %h expected %h", {minutes, seconds, running, done, buzz}, exp_vec()); end
    disMode = 2'd2;
    step();
  endtask

  task automatic test_pause_tick();
    press(3, 0);
    editCur = 3'd5;
    repeat (5) press(1, 0);
    press(0, 0);
    press(0, 1);
    checks++; if ({seconds, running} !== {6'd5, 1'b0}) begin errors++; $display("FAIL pause_drops_tick: got %0d run=%b expected 5 run=0", seconds, running); end
    press(1, 0);
    checks++; if (seconds !== 6'd6) begin errors++; $display("FAIL pause_edit: got %0d expected 6", seconds); end
    press(0, 0);
    checks++; if ({seconds, running} !== {6'd6, 1'b1}) begin errors++; $display("FAIL resume: got %0d run=%b expected 6 run=1", seconds, running); end
    tick_once();
    checks++; if (seconds !== 6'd5) begin errors++; $display("FAIL resume_tick: got %0d expected 5", seconds); end
  endtask

  task automatic test_idle_zero();
    press(3, 0);
    press(0, 0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL start_at_zero: got %b expected 0", running); end
    disMode = 2'd0; editCur = 3'd5;
    press(1, 0);
    checks++; if ({minutes, seconds} !== 12'd0) begin errors++; $display("FAIL foreign_mode: got %0d:%0d expected 0:0", minutes, seconds); end
    disMode = 2'd2;
  endtask

  task automatic test_reset_mid_run();
    press(3, 0);
    editCur = 3'd2; press(1, 0);
    editCur = 3'd3; repeat (2) press(1, 0);
    editCur = 3'd4; repeat (3) press(1, 0);
    editCur = 3'd5; repeat (4) press(1, 0);
    press(0, 0);
    checks++; if ({minutes, seconds, running} !== {6'd12, 6'd34, 1'b1}) begin errors++; $display("FAIL run_1234: got %0d:%0d run=%b expected 12:34 run=1", minutes, seconds, running); end
    @(negedge Clk); #2;
    nReset = 1'b0; KEY[0] = 1'b0;
    model_reset();
    #1;
    checks++; if ({minutes, seconds, running, buzz, done} !== 15'd0) begin errors++; $display("FAIL async_reset: got %0d:%0d run=%b buzz=%b done=%b expected all 0", minutes, seconds, running, buzz, done); end
    @(negedge Clk); nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (running !== 1'b0) begin errors++; $display("FAIL held_start: got %b expected 0", running); end
    end
    KEY = 4'hF; step(); step();
    editCur = 3'd5; press(1, 0); press(0, 0); tick_once();
    checks++; if (buzz !== 1'b1) begin errors++; $display("FAIL buzz_before_reset: got %b expected 1", buzz); end
    @(negedge Clk); #2;
    nReset = 1'b0;
    model_reset();
    #1;
    checks++; if ({buzz, done, running} !== 3'b000) begin errors++; $display("FAIL reset_mid_buzz: got %b expected 000", {buzz, done, running}); end
    @(negedge Clk); nReset = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) KEY[0] = ~KEY[0];
      if ($urandom_range(0, 3) == 0) KEY[1] = ~KEY[1];
      if ($urandom_range(0, 5) == 0) KEY[2] = ~KEY[2];
      if ($urandom_range(0, 59) == 0) KEY[3] = ~KEY[3];
      tick = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) editCur = 3'($urandom_range(0, 7));
      disMode = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      step();
      checks++;
      if ({minutes, seconds, running, done, buzz} !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %0d:%0d r%b d%b b%b expected %0d:%0d r%b d%b b%b", i,
                 minutes, seconds, running, done, buzz, m_total / 60, m_total % 60,
                 m_state == M_RUN, m_done, m_buzz);
      end
    end
    KEY = 4'hF; tick = 1'b0; disMode = 2'd2;
  endtask

  initial begin
    test_reset();
    test_preset();
    test_expire();
    test_pause_tick();
    test_idle_zero();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
